// File: rtl/snake_step_if.sv
// Signal bundle between the direction/food logic, the step controller and the
// snake body shift register. The slave side is the step controller itself.
interface snake_step_if;
  logic        start;
  logic        dir_up;
  logic        dir_down;
  logic        dir_left;
  logic        dir_right;
  logic        food_eaten;
  logic        collision_in;
  logic        shift_enable;
  logic [10:0] horizontal_head_coord;
  logic [10:0] vertical_head_coord;
  logic [9:0]  active_mask;
  logic        body_clear;
  logic        game_over;
  logic [6:0]  score;
  logic [2:0]  state;

  modport master (
    output start, dir_up, dir_down, dir_left, dir_right, food_eaten, collision_in,
    input  shift_enable, horizontal_head_coord, vertical_head_coord, active_mask,
           body_clear, game_over, score, state
  );

  modport slave (
    input  start, dir_up, dir_down, dir_left, dir_right, food_eaten, collision_in,
    output shift_enable, horizontal_head_coord, vertical_head_coord, active_mask,
           body_clear, game_over, score, state
  );
endinterface

// File: rtl/snake_step_controller.sv
// Snake game sequencer: step timing, next-head computation, body length mask,
// wall and self-collision checks.
//
// state  | meaning
// IDLE   | waiting for the first start pulse
// RUN    | tick counter running, direction requests latched
// STEP   | one-cycle shift strobe, new head and mask presented
// CHECK1 | wait for the shift register's collision flag to settle
// CHECK2 | sample collision_in
// LOST   | game over, outputs frozen until start
module snake_step_controller #(
  parameter int TICK_CYCLES = 2500000,
  parameter int CELL        = 20,
  parameter int H_MAX       = 620,
  parameter int V_MAX       = 460,
  parameter int START_H     = 320,
  parameter int START_V     = 240
) (
  input  logic       clock,
  input  logic       reset,
  snake_step_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_CHECK1 = 3'd3,
    S_CHECK2 = 3'd4,
    S_LOST   = 3'd5
  } state_t;

  // Encoding chosen so that opposite directions differ only in bit 0.
  typedef enum logic [1:0] {
    D_UP    = 2'd0,
    D_DOWN  = 2'd1,
    D_LEFT  = 2'd2,
    D_RIGHT = 2'd3
  } dir_t;

  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 2;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d, req_dir;
  logic [TW-1:0] tick_q, tick_d;
  logic [10:0]   head_h_q, head_h_d, head_v_q, head_v_d;
  logic [10:0]   next_h, next_v;
  logic [11:0]   h_ext, v_ext;
  logic [3:0]    len_q, len_d;
  logic          grow_q, grow_d;
  logic [6:0]    score_q, score_d;
  logic [9:0]    mask_q, mask_d;
  logic          clear_q, clear_d;
  logic          req_valid, req_opposite, wall;

  function automatic logic [9:0] mask_for(input logic [3:0] n);
    logic [9:0] m;
    for (int i = 0; i < 10; i++) m[i] = (i <= int'(n));
    return m;
  endfunction

  assign h_ext = {1'b0, head_h_q};
  assign v_ext = {1'b0, head_v_q};

  // Candidate head one cell ahead in the latched direction, plus wall detection.
  always_comb begin
    next_h = head_h_q;
    next_v = head_v_q;
    wall   = 1'b0;
    case (dir_q)
      D_UP:    if (v_ext < 12'(CELL)) wall = 1'b1;
               else next_v = head_v_q - 11'(CELL);
      D_DOWN:  if (v_ext + 12'(CELL) > 12'(V_MAX)) wall = 1'b1;
               else next_v = head_v_q + 11'(CELL);
      D_LEFT:  if (h_ext < 12'(CELL)) wall = 1'b1;
               else next_h = head_h_q - 11'(CELL);
      default: if (h_ext + 12'(CELL) > 12'(H_MAX)) wall = 1'b1;
               else next_h = head_h_q + 11'(CELL);
    endcase
  end

  // Highest-priority direction request: up > down > left > right.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = dir_q;
    if (bus.dir_up)         req_dir = D_UP;
    else if (bus.dir_down)  req_dir = D_DOWN;
    else if (bus.dir_left)  req_dir = D_LEFT;
    else if (bus.dir_right) req_dir = D_RIGHT;
    else                    req_valid = 1'b0;
  end

  assign req_opposite = ((req_dir ^ dir_q) == 2'b01);

  // Next-state and datapath update for the step sequencer.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    dir_d    = dir_q;
    head_h_d = head_h_q;
    head_v_d = head_v_q;
    len_d    = len_q;
    grow_d   = grow_q;
    score_d  = score_q;
    mask_d   = mask_q;
    clear_d  = 1'b0;

    if (bus.food_eaten && state_q != S_IDLE && state_q != S_LOST) grow_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          mask_d  = 10'h001;
        end
      end
      S_RUN: begin
        // A reversal would run the head straight into its own neck.
        if (req_valid && !(len_q != 4'd0 && req_opposite)) dir_d = req_dir;
        if (tick_q == TICK_LAST) begin
          if (wall) begin
            state_d = S_LOST;
          end else begin
            state_d  = S_STEP;
            tick_d   = '0;
            head_h_d = next_h;
            head_v_d = next_v;
            // Growth is committed here so the new mask is valid through STEP;
            // food arriving in this cycle waits for the following step.
            grow_d   = bus.food_eaten;
            if (grow_q) begin
              if (score_q < 7'd99) score_d = score_q + 7'd1;
              if (len_q < 4'd9)    len_d   = len_q + 4'd1;
            end
            mask_d = mask_for(len_d);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_STEP:   state_d = S_CHECK1;
      S_CHECK1: state_d = S_CHECK2;
      S_CHECK2: state_d = bus.collision_in ? S_LOST : S_RUN;
      S_LOST: begin
        if (bus.start) begin
          state_d  = S_RUN;
          tick_d   = '0;
          dir_d    = D_RIGHT;
          head_h_d = 11'(START_H);
          head_v_d = 11'(START_V);
          len_d    = 4'd0;
          grow_d   = 1'b0;
          score_d  = 7'd0;
          mask_d   = 10'h001;
          clear_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      dir_q    <= D_RIGHT;
      head_h_q <= 11'(START_H);
      head_v_q <= 11'(START_V);
      len_q    <= 4'd0;
      grow_q   <= 1'b0;
      score_q  <= 7'd0;
      mask_q   <= 10'h000;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      dir_q    <= dir_d;
      head_h_q <= head_h_d;
      head_v_q <= head_v_d;
      len_q    <= len_d;
      grow_q   <= grow_d;
      score_q  <= score_d;
      mask_q   <= mask_d;
      clear_q  <= clear_d;
    end
  end

  assign bus.shift_enable          = (state_q == S_STEP);
  assign bus.game_over             = (state_q == S_LOST);
  assign bus.horizontal_head_coord = head_h_q;
  assign bus.vertical_head_coord   = head_v_q;
  assign bus.active_mask           = mask_q;
  assign bus.body_clear            = clear_q;
  assign bus.score                 = score_q;
  assign bus.state                 = state_q;

endmodule

// File: tb/tb_snake_step_controller.sv
// Self-checking bench for snake_step_controller with a step scoreboard.
module tb_snake_step_controller;
  localparam int TICK  = 4;
  localparam int CELL  = 20;
  localparam int H_MAX = 620;
  localparam int V_MAX = 460;
  localparam int SH    = 320;
  localparam int SV    = 240;

  logic clock = 1'b0;
  logic reset;
  snake_step_if bus();

  snake_step_controller #(
    .TICK_CYCLES(TICK), .CELL(CELL), .H_MAX(H_MAX), .V_MAX(V_MAX),
    .START_H(SH), .START_V(SV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // expected step record: {h[10:0], v[10:0], mask[9:0], score[6:0]}
  logic [38:0] exp_q[$];

  // reference model; dir 0=up 1=down 2=left 3=right
  int m_h, m_v, m_dir, m_len, m_score;
  bit m_grow;

  task automatic model_init();
    m_h = SH; m_v = SV; m_dir = 3; m_len = 0; m_score = 0; m_grow = 0;
    exp_q.delete();
  endtask

  task automatic model_dir(input bit u, input bit d, input bit l, input bit r);
    int req;
    req = -1;
    if (u) req = 0; else if (d) req = 1; else if (l) req = 2; else if (r) req = 3;
    if (req < 0) return;
    if (m_len > 0 && req / 2 == m_dir / 2 && req != m_dir) return;
    m_dir = req;
  endtask

  task automatic model_step(output bit wall);
    int nh, nv;
    logic [9:0] mk;
    nh = m_h; nv = m_v;
    case (m_dir)
      0: nv = nv - CELL;
      1: nv = nv + CELL;
      2: nh = nh - CELL;
      default: nh = nh + CELL;
    endcase
    wall = (nh < 0 || nh > H_MAX || nv < 0 || nv > V_MAX);
    if (!wall) begin
      m_h = nh; m_v = nv;
      if (m_grow) begin
        if (m_score < 99) m_score++;
        if (m_len < 9) m_len++;
        m_grow = 0;
      end
      for (int i = 0; i < 10; i++) mk[i] = (i <= m_len);
      exp_q.push_back({11'(m_h), 11'(m_v), mk, 7'(m_score)});
    end
  endtask

  function automatic logic [38:0] pop_exp();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  task automatic wait_step(output bit ok, output logic [38:0] obs, output int ncyc);
    ok = 0; obs = '0; ncyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (bus.shift_enable === 1'b1) begin
        ok = 1; ncyc = i;
        obs = {bus.horizontal_head_coord, bus.vertical_head_coord, bus.active_mask, bus.score};
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] s, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.state === s) begin ok = 1; break; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 0; bus.dir_up = 0; bus.dir_down = 0; bus.dir_left = 0;
    bus.dir_right = 0; bus.food_eaten = 0; bus.collision_in = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    model_init();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic food_in_run();
    for (int i = 0; i < 20 && bus.state !== 3'd1; i++) @(negedge clock);
    bus.food_eaten = 1'b1;
    @(negedge clock);
    bus.food_eaten = 1'b0;
    m_grow = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.state !== 3'd0 || bus.shift_enable !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got state=%0d se=%b want 0 0", bus.state, bus.shift_enable);
    end
    n_checks++;
    if (bus.horizontal_head_coord !== 11'(SH) || bus.vertical_head_coord !== 11'(SV)) begin
      n_fail++; $display("FAIL reset_head: got (%0d,%0d) want (%0d,%0d)",
        bus.horizontal_head_coord, bus.vertical_head_coord, SH, SV);
    end
    n_checks++;
    if (bus.active_mask !== 10'h000 || bus.score !== 7'd0 || bus.body_clear !== 1'b0 || bus.game_over !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs: got mask=%h score=%0d bc=%b go=%b want 0 0 0 0",
        bus.active_mask, bus.score, bus.body_clear, bus.game_over);
    end
  endtask

  task automatic test_first_step();
    bit ok, w; logic [38:0] obs, exp; int nc;
    do_start();
    n_checks++;
    if (bus.state !== 3'd1 || bus.active_mask !== 10'h001) begin
      n_fail++; $display("FAIL start_run: got state=%0d mask=%h want 1 001", bus.state, bus.active_mask);
    end
    model_step(w);
    wait_step(ok, obs, nc);
    exp = pop_exp();
    n_checks++;
    if (!ok || nc != TICK) begin
      n_fail++; $display("FAIL step_latency: got %0d cycles ok=%0d want %0d", nc, ok, TICK);
    end
    n_checks++;
    if (obs !== exp || bus.state !== 3'd2) begin
      n_fail++; $display("FAIL first_step: got %h state=%0d want %h state 2", obs, bus.state, exp);
    end
    @(negedge clock);
    n_checks++;
    if (bus.shift_enable !== 1'b0 || bus.state !== 3'd3) begin
      n_fail++; $display("FAIL strobe_width: got se=%b state=%0d want 0 3", bus.shift_enable, bus.state);
    end
  endtask

  task automatic test_grow();
    bit ok, w; logic [38:0] obs, exp; int nc;
    do_reset(); do_start();
    for (int k = 1; k <= 12; k++) begin
      food_in_run();
      model_step(w);
      wait_step(ok, obs, nc);
      exp = pop_exp();
      n_checks++;
      if (!ok || obs !== exp) begin
        n_fail++; $display("FAIL grow_step%0d: got %h ok=%0d want %h", k, obs, ok, exp);
      end
    end
    n_checks++;
    if (bus.active_mask !== 10'h3FF || bus.score !== 7'd12) begin
      n_fail++; $display("FAIL grow_final: got mask=%h score=%0d want 3ff 12", bus.active_mask, bus.score);
    end
  endtask

  task automatic test_direction();
    bit ok, w; logic [38:0] obs, exp; int nc;
    logic [3:0] pat[5];
    pat[0] = 4'b0000; pat[1] = 4'b0000; pat[2] = 4'b0010; pat[3] = 4'b1000; pat[4] = 4'b1010;
    do_reset(); do_start();
    for (int k = 0; k < 6; k++) begin
      if (k < 2) food_in_run();
      if (k < 5) begin
        {bus.dir_up, bus.dir_down, bus.dir_left, bus.dir_right} = pat[k];
        model_dir(pat[k][3], pat[k][2], pat[k][1], pat[k][0]);
      end else begin
        {bus.dir_up, bus.dir_down, bus.dir_left, bus.dir_right} = 4'b0000;
      end
      model_step(w);
      wait_step(ok, obs, nc);
      exp = pop_exp();
      n_checks++;
      if (!ok || obs !== exp) begin
        n_fail++; $display("FAIL dir_step%0d: got %h ok=%0d want %h", k, obs, ok, exp);
      end
    end
    {bus.dir_up, bus.dir_down, bus.dir_left, bus.dir_right} = 4'b0000;
  endtask

  task automatic test_wall();
    bit ok, w, seen; logic [38:0] obs, exp; int nc;
    do_reset(); do_start();
    for (int k = 0; k < 15; k++) begin
      model_step(w);
      wait_step(ok, obs, nc);
      exp = pop_exp();
      n_checks++;
      if (!ok || obs !== exp) begin
        n_fail++; $display("FAIL wall_step%0d: got %h ok=%0d want %h", k, obs, ok, exp);
      end
    end
    model_step(w);
    n_checks++;
    if (!w) begin
      n_fail++; $display("FAIL wall_model: got no wall want wall at x=%0d", m_h);
    end
    seen = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.shift_enable === 1'b1) seen = 1;
      if (bus.state === 3'd5) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok || seen || bus.game_over !== 1'b1) begin
      n_fail++; $display("FAIL wall_lost: got lost=%0d strobe=%0d go=%b want 1 0 1", ok, seen, bus.game_over);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.horizontal_head_coord !== 11'd620 || bus.state !== 3'd5 || bus.shift_enable !== 1'b0) begin
      n_fail++; $display("FAIL wall_hold: got x=%0d state=%0d se=%b want 620 5 0",
        bus.horizontal_head_coord, bus.state, bus.shift_enable);
    end
  endtask

  task automatic test_collision();
    bit ok, w; logic [38:0] obs, exp; int nc;
    do_reset(); do_start();
    model_step(w);
    wait_step(ok, obs, nc);
    exp = pop_exp();
    @(negedge clock);
    bus.collision_in = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus.collision_in = 1'b0;
    n_checks++;
    if (bus.state !== 3'd5 || bus.game_over !== 1'b1) begin
      n_fail++; $display("FAIL coll_check2: got state=%0d go=%b want 5 1", bus.state, bus.game_over);
    end
    do_reset(); do_start();
    bus.collision_in = 1'b1;
    repeat (3) @(negedge clock);
    bus.collision_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      model_step(w);
      wait_step(ok, obs, nc);
      exp = pop_exp();
      n_checks++;
      if (!ok || obs !== exp) begin
        n_fail++; $display("FAIL coll_run_step%0d: got %h ok=%0d want %h", k, obs, ok, exp);
      end
      if (k == 0) begin
        repeat (3) @(negedge clock);
        n_checks++;
        if (bus.state !== 3'd1) begin
          n_fail++; $display("FAIL coll_run_ignored: got state=%0d want 1", bus.state);
        end
      end
    end
  endtask

  task automatic test_reset_and_restart();
    bit ok, w; logic [38:0] obs, exp; int nc;
    do_reset(); do_start();
    food_in_run();
    model_step(w);
    wait_step(ok, obs, nc);
    exp = pop_exp();
    n_checks++;
    if (!ok || obs !== exp) begin
      n_fail++; $display("FAIL pre_reset_step: got %h ok=%0d want %h", obs, ok, exp);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.shift_enable !== 1'b0 || bus.state !== 3'd0 ||
        bus.horizontal_head_coord !== 11'(SH) || bus.vertical_head_coord !== 11'(SV) ||
        bus.active_mask !== 10'h000 || bus.score !== 7'd0) begin
      n_fail++; $display("FAIL async_reset: got se=%b state=%0d head=(%0d,%0d) mask=%h score=%0d want 0 0 (320,240) 0 0",
        bus.shift_enable, bus.state, bus.horizontal_head_coord, bus.vertical_head_coord,
        bus.active_mask, bus.score);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    model_init();
    do_start();
    food_in_run();
    bus.dir_up = 1'b1;
    model_dir(1, 0, 0, 0);
    model_step(w);
    wait_step(ok, obs, nc);
    exp = pop_exp();
    bus.dir_up = 1'b0;
    n_checks++;
    if (!ok || obs !== exp) begin
      n_fail++; $display("FAIL up_step: got %h ok=%0d want %h", obs, ok, exp);
    end
    @(negedge clock);
    bus.collision_in = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus.collision_in = 1'b0;
    n_checks++;
    if (bus.state !== 3'd5 || bus.score !== 7'd1) begin
      n_fail++; $display("FAIL lost_score: got state=%0d score=%0d want 5 1", bus.state, bus.score);
    end
    model_init();
    do_start();
    n_checks++;
    if (bus.body_clear !== 1'b1 || bus.state !== 3'd1 || bus.score !== 7'd0 ||
        bus.active_mask !== 10'h001 || bus.game_over !== 1'b0 ||
        bus.horizontal_head_coord !== 11'(SH) || bus.vertical_head_coord !== 11'(SV)) begin
      n_fail++; $display("FAIL restart: got bc=%b state=%0d score=%0d mask=%h go=%b head=(%0d,%0d) want 1 1 0 001 0 (320,240)",
        bus.body_clear, bus.state, bus.score, bus.active_mask, bus.game_over,
        bus.horizontal_head_coord, bus.vertical_head_coord);
    end
    model_step(w);
    wait_step(ok, obs, nc);
    exp = pop_exp();
    n_checks++;
    if (!ok || obs !== exp || nc != TICK) begin
      n_fail++; $display("FAIL restart_step: got %h ok=%0d cyc=%0d want %h cyc %0d", obs, ok, nc, exp, TICK);
    end
  endtask

  task automatic test_body_clear_width();
    bit ok;
    do_reset(); do_start();
    bus.collision_in = 1'b1;
    wait_state(3'd5, ok);
    bus.collision_in = 1'b0;
    do_start();
    @(negedge clock);
    n_checks++;
    if (!ok || bus.body_clear !== 1'b0 || bus.state !== 3'd1) begin
      n_fail++; $display("FAIL body_clear_width: got lost=%0d bc=%b state=%0d want 1 0 1",
        ok, bus.body_clear, bus.state);
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_grow();
    test_direction();
    test_wall();
    test_collision();
    test_reset_and_restart();
    test_body_clear_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
